// File: rtl/pc_pkg.sv
// pc_pkg: shared decode constants and FSM state type for the program-counter unit.
//   opcode / regimm rt / funct encodings for every control-flow instruction,
//   and pc_state_t {RUN, DELAY, HALTED}.
package pc_pkg;

    // Primary opcodes [31:26]
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    // REGIMM rt field [20:16]
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // SPECIAL funct field [5:0]
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [1:0] {RUN, DELAY, HALTED} pc_state_t;

endpackage

// File: rtl/pc_branch_decode.sv
// pc_branch_decode: combinational control-flow decode for the instruction in execute.
//   instruction_word  in  32  instruction at addr
//   N, Z              in  1   ALU flags for that instruction
//   addr              in  32  address of that instruction
//   read_data_0       in  32  rs value (JR/JALR target)
//   taken             out 1   control transfer happens
//   target            out 32  destination when taken
//   is_link           out 1   instruction writes a return address
//   is_reg_jump       out 1   JR/JALR (target comes from a register)
module pc_branch_decode
    import pc_pkg::*;
(
    input  logic [31:0] instruction_word,
    input  logic        N,
    input  logic        Z,
    input  logic [31:0] addr,
    input  logic [31:0] read_data_0,
    output logic        taken,
    output logic [31:0] target,
    output logic        is_link,
    output logic        is_reg_jump
);

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [31:0] seq_addr;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign opcode    = instruction_word[31:26];
    assign rt        = instruction_word[20:16];
    assign funct     = instruction_word[5:0];
    assign seq_addr  = addr + 32'd4;
    assign br_target = seq_addr + {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00};
    // J/JAL stay inside the 256 MB region of the delay-slot address
    assign j_target  = {seq_addr[31:28], instruction_word[25:0], 2'b00};

    always_comb begin
        taken       = 1'b0;
        target      = br_target;
        is_link     = 1'b0;
        is_reg_jump = 1'b0;
        unique case (opcode)
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    taken       = 1'b1;
                    target      = read_data_0;
                    is_reg_jump = 1'b1;
                    is_link     = (funct == FN_JALR);
                end
            end
            OP_REGIMM: begin
                unique case (rt)
                    RT_BLTZ:   taken = N;
                    RT_BGEZ:   taken = !N;
                    RT_BLTZAL: begin taken = N;  is_link = 1'b1; end
                    RT_BGEZAL: begin taken = !N; is_link = 1'b1; end
                    default:   taken = 1'b0;
                endcase
            end
            OP_J:    begin taken = 1'b1; target = j_target; end
            OP_JAL:  begin taken = 1'b1; target = j_target; is_link = 1'b1; end
            OP_BEQ:  taken = Z;
            OP_BNE:  taken = !Z;
            OP_BLEZ: taken = N | Z;
            OP_BGTZ: taken = !N & !Z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch-delay-slot handling, halt detection and
// misaligned register-jump fault.
//   clk, reset        in  1   clock; synchronous active-high reset
//   state             in  1   core phase (0 fetch, 1 execute)
//   stall             in  1   freeze all updates
//   N, Z              in  1   ALU flags of the executing instruction
//   instruction_word  in  32  executing instruction
//   read_data_0       in  32  rs value for JR/JALR
//   addr              out 32  fetch address
//   B_link            out 1   executing instruction links (comb)
//   link_addr         out 32  return address
//   finish            out 1   halted
//   addr_err          out 1   sticky misaligned register-jump fault
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        state,
    input  logic        stall,
    input  logic        N,
    input  logic        Z,
    input  logic [31:0] instruction_word,
    input  logic [31:0] read_data_0,
    output logic [31:0] addr,
    output logic        B_link,
    output logic [31:0] link_addr,
    output logic        finish,
    output logic        addr_err
);

    pc_state_t   fsm, fsm_next;
    logic [31:0] pending, pending_next, addr_next;
    logic        finish_next, addr_err_next;
    logic        advance;
    logic        taken, is_link, is_reg_jump;
    logic [31:0] target;

    pc_branch_decode u_dec (
        .instruction_word (instruction_word),
        .N                (N),
        .Z                (Z),
        .addr             (addr),
        .read_data_0      (read_data_0),
        .taken            (taken),
        .target           (target),
        .is_link          (is_link),
        .is_reg_jump      (is_reg_jump)
    );

    assign advance = state && !stall && (fsm != HALTED);

    // The delay-slot instruction is never treated as control flow, so its
    // link request is suppressed as well.
    assign B_link    = is_link && (fsm == RUN);
    assign link_addr = addr + (DELAY_SLOT ? 32'd8 : 32'd4);

    always_comb begin
        fsm_next      = fsm;
        addr_next     = addr;
        pending_next  = pending;
        finish_next   = finish;
        addr_err_next = addr_err;
        if (advance) begin
            unique case (fsm)
                RUN: begin
                    if (is_reg_jump && read_data_0[1:0] != 2'b00) begin
                        // fault stops immediately; delay slot is not executed
                        addr_err_next = 1'b1;
                        finish_next   = 1'b1;
                        fsm_next      = HALTED;
                    end else if (!taken) begin
                        addr_next = addr + 32'd4;
                    end else if (DELAY_SLOT) begin
                        addr_next    = addr + 32'd4;
                        pending_next = target;
                        fsm_next     = DELAY;
                    end else if (target == HALT_ADDR) begin
                        finish_next = 1'b1;
                        fsm_next    = HALTED;
                    end else begin
                        addr_next = target;
                    end
                end
                DELAY: begin
                    if (pending == HALT_ADDR) begin
                        finish_next = 1'b1;
                        fsm_next    = HALTED;
                    end else begin
                        addr_next = pending;
                        fsm_next  = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= RUN;
            addr     <= RESET_VECTOR;
            pending  <= 32'd0;
            finish   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            fsm      <= fsm_next;
            addr     <= addr_next;
            pending  <= pending_next;
            finish   <= finish_next;
            addr_err <= addr_err_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: three pc_unit builds driven by shared stimulus, each checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_pc_unit;

    localparam logic [31:0] NOP  = 32'h0060_000B;
    localparam logic [31:0] BLTZ = 32'h0400_0002;
    localparam logic [31:0] JR   = 32'h03E0_0008;

    logic clk = 1'b0;
    logic reset = 1'b1, state = 1'b0, stall = 1'b0, N = 1'b0, Z = 1'b0;
    logic [31:0] iw = 32'd0, rd = 32'd0;
    always #5 clk = ~clk;

    logic [31:0] addr_a, addr_b, addr_c, la_a, la_b, la_c;
    logic        bl_a, bl_b, bl_c, fin_a, fin_b, fin_c, err_a, err_b, err_c;

    pc_unit dut_a (.clk(clk), .reset(reset), .state(state), .stall(stall), .N(N), .Z(Z),
        .instruction_word(iw), .read_data_0(rd), .addr(addr_a), .B_link(bl_a),
        .link_addr(la_a), .finish(fin_a), .addr_err(err_a));
    pc_unit #(.RESET_VECTOR(32'h0), .HALT_ADDR(32'hFFFF_FFFC), .DELAY_SLOT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .state(state), .stall(stall), .N(N), .Z(Z),
        .instruction_word(iw), .read_data_0(rd), .addr(addr_b), .B_link(bl_b),
        .link_addr(la_b), .finish(fin_b), .addr_err(err_b));
    pc_unit #(.RESET_VECTOR(32'h0), .HALT_ADDR(32'hFFFF_FFFC), .DELAY_SLOT(1'b0)) dut_c (
        .clk(clk), .reset(reset), .state(state), .stall(stall), .N(N), .Z(Z),
        .instruction_word(iw), .read_data_0(rd), .addr(addr_c), .B_link(bl_c),
        .link_addr(la_c), .finish(fin_c), .addr_err(err_c));

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pend;
        int          mode;   // 0 running, 1 delay slot pending, 2 stopped
        logic        fin;
        logic        err;
    } mdl_t;

    typedef struct {
        bit          taken;
        bit          link;
        bit          reg_j;
        logic [31:0] tgt;
    } dec_t;

    mdl_t m_a, m_b, m_c;
    int   checks = 0, failures = 0;
    bit   mon_en = 1'b0;

    function automatic dec_t dec(logic [31:0] pc, logic [31:0] w, bit n, bit z, logic [31:0] r);
        dec_t        d;
        int          off;
        logic [31:0] br, jt;
        logic [4:0]  rt;
        d.taken = 0; d.link = 0; d.reg_j = 0;
        off = int'($signed(w[15:0])) * 4;
        br  = pc + 32'd4 + 32'(off);
        jt  = ((pc + 32'd4) & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
        d.tgt = br;
        rt  = w[20:16];
        case (w[31:26])
            6'd0: if (w[5:0] == 6'd8 || w[5:0] == 6'd9) begin
                      d.taken = 1; d.reg_j = 1; d.tgt = r; d.link = (w[5:0] == 6'd9);
                  end
            6'd1: if (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17) begin
                      d.taken = rt[0] ? !n : n;
                      d.link  = rt[4];
                  end
            6'd2, 6'd3: begin d.taken = 1; d.tgt = jt; d.link = (w[31:26] == 6'd3); end
            6'd4: d.taken = z;
            6'd5: d.taken = !z;
            6'd6: d.taken = n || z;
            6'd7: d.taken = !n && !z;
            default: ;
        endcase
        return d;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [31:0] rv, logic [31:0] halt, bit ds);
        mdl_t r;
        dec_t d;
        r = m;
        if (reset) begin
            r.addr = rv; r.pend = 0; r.mode = 0; r.fin = 0; r.err = 0;
            return r;
        end
        if (!state || stall || m.mode == 2) return r;
        if (m.mode == 1) begin
            if (m.pend == halt) begin r.mode = 2; r.fin = 1; end
            else begin r.addr = m.pend; r.mode = 0; end
            return r;
        end
        d = dec(m.addr, iw, N, Z, rd);
        if (d.reg_j && (rd % 4) != 0) begin
            r.err = 1; r.fin = 1; r.mode = 2;
        end else if (!d.taken) r.addr = m.addr + 4;
        else if (ds) begin r.addr = m.addr + 4; r.pend = d.tgt; r.mode = 1; end
        else if (d.tgt == halt) begin r.fin = 1; r.mode = 2; end
        else r.addr = d.tgt;
        return r;
    endfunction

    function automatic bit exp_link(mdl_t m);
        dec_t d;
        d = dec(m.addr, iw, N, Z, rd);
        return (m.mode == 0) && d.link;
    endfunction

    always @(posedge clk) begin
        m_a <= mstep(m_a, 32'hBFC0_0000, 32'h0, 1'b1);
        m_b <= mstep(m_b, 32'h0, 32'hFFFF_FFFC, 1'b1);
        m_c <= mstep(m_c, 32'h0, 32'hFFFF_FFFC, 1'b0);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("a_addr", addr_a, m_a.addr); chk("a_finish", fin_a, m_a.fin); chk("a_err", err_a, m_a.err);
            chk("b_addr", addr_b, m_b.addr); chk("b_finish", fin_b, m_b.fin); chk("b_err", err_b, m_b.err);
            chk("c_addr", addr_c, m_c.addr); chk("c_finish", fin_c, m_c.fin); chk("c_err", err_c, m_c.err);
            if (state) begin
                chk("a_b_link", bl_a, exp_link(m_a)); chk("a_link_addr", la_a, m_a.addr + 8);
                chk("b_b_link", bl_b, exp_link(m_b)); chk("b_link_addr", la_b, m_b.addr + 8);
                chk("c_b_link", bl_c, exp_link(m_c)); chk("c_link_addr", la_c, m_c.addr + 4);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit s, bit st, bit n, bit z, logic [31:0] w, logic [31:0] r);
        state = s; stall = st; N = n; Z = z; iw = w; rd = r;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exec(logic [31:0] w, bit n, bit z, logic [31:0] r);
        drive(0, 0, 0, 0, NOP, 0); tick;
        drive(1, 0, n, z, w, r);   tick;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(0, 0, 0, 0, NOP, 0);
        tick; tick;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r32, w, r;
        int k;

        do_reset;
        mon_en = 1'b1;
        chk("rst_a_addr", addr_a, 32'hBFC0_0000);
        chk("rst_b_addr", addr_b, 32'h0);
        chk("rst_a_finish", fin_a, 0);
        chk("rst_a_err", err_a, 0);

        exec(NOP, 0, 0, 0); chk("seq_1", addr_a, 32'hBFC0_0004);
        drive(0, 0, 0, 0, NOP, 0); tick; chk("fetch_hold", addr_a, 32'hBFC0_0004);
        exec(NOP, 0, 0, 0); chk("seq_2", addr_a, 32'hBFC0_0008);
        exec(NOP, 0, 0, 0); chk("seq_3", addr_a, 32'hBFC0_000C);

        // BLTZ taken / not taken
        do_reset; exec(NOP, 0, 0, 0); exec(NOP, 0, 0, 0);
        chk("bltz_start", addr_b, 32'd8);
        exec(BLTZ, 1, 0, 0); chk("bltz_t_slot", addr_b, 32'd12); chk("bltz_t_nods", addr_c, 32'd20);
        exec(NOP, 0, 0, 0);  chk("bltz_t_tgt", addr_b, 32'd20);
        do_reset; exec(NOP, 0, 0, 0); exec(NOP, 0, 0, 0);
        exec(BLTZ, 0, 0, 0); chk("bltz_nt_1", addr_b, 32'd12);
        exec(NOP, 0, 0, 0);  chk("bltz_nt_2", addr_b, 32'd16);

        // JAL at 0x100
        do_reset; exec(32'h0800_0040, 0, 0, 0); exec(NOP, 0, 0, 0);
        chk("j_0x100", addr_b, 32'h100);
        drive(0, 0, 0, 0, NOP, 0); tick;
        drive(1, 0, 0, 0, 32'h0C00_0004, 0);
        chk("jal_b_link", bl_b, 1); chk("jal_link_addr", la_b, 32'h108);
        tick; chk("jal_slot", addr_b, 32'h104);
        exec(NOP, 0, 0, 0); chk("jal_tgt", addr_b, 32'h010);

        // halt through JR to HALT_ADDR
        do_reset; exec(JR, 0, 0, 0);
        chk("halt_slot", addr_a, 32'hBFC0_0004); chk("halt_early", fin_a, 0);
        exec(NOP, 0, 0, 0); chk("halt_fin", fin_a, 1); chk("halt_addr", addr_a, 32'hBFC0_0004);
        repeat (10) exec(NOP, 0, 0, 0);
        chk("halt_frozen", addr_a, 32'hBFC0_0004); chk("halt_fin_hold", fin_a, 1);

        // misaligned JR
        do_reset; exec(JR, 0, 0, 32'h1002);
        chk("mis_err", err_a, 1); chk("mis_fin", fin_a, 1); chk("mis_addr", addr_a, 32'hBFC0_0000);

        // stall in the delay slot, then reset in the delay slot
        do_reset; exec(NOP, 0, 0, 0); exec(NOP, 0, 0, 0); exec(BLTZ, 1, 0, 0);
        drive(1, 1, 0, 0, NOP, 0); repeat (5) tick;
        chk("stall_hold", addr_b, 32'd12);
        exec(NOP, 0, 0, 0); chk("stall_release", addr_b, 32'd20);
        exec(BLTZ, 1, 0, 0); chk("rst_dly_slot", addr_b, 32'd24);
        reset = 1'b1; drive(1, 0, 1, 0, BLTZ, 0); tick; reset = 1'b0;
        chk("rst_dly_addr", addr_b, 32'd0);
        exec(NOP, 0, 0, 0); chk("rst_dly_run", addr_b, 32'd4);

        // no delay slot: BEQ at 0x20
        do_reset; repeat (8) exec(NOP, 0, 0, 0);
        chk("beq_start", addr_c, 32'h20);
        exec(32'h1000_0003, 0, 1, 0); chk("beq_nods", addr_c, 32'h30);

        // randomized traffic
        do_reset;
        for (int i = 0; i < 3000; i++) begin
            r32 = $urandom;
            k = $urandom_range(0, 4);
            case (k)
                0: w = r32;
                1: begin
                       r = 32'($urandom_range(0, 3));
                       w = {6'h01, r32[25:21], r[1] ? 4'h8 : 4'h0, r[0], r32[15:0]};
                   end
                2: w = {6'($urandom_range(2, 7)), r32[25:0]};
                3: w = {6'h00, r32[25:6], 6'(8 + $urandom_range(0, 1))};
                default: w = NOP;
            endcase
            r = $urandom;
            if ($urandom_range(0, 9) != 0) r[1:0] = 2'b00;
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, r);
            tick;
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, NOP, 0); tick;

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the Harvard MIPS core, replacing the fixed two-phase PC. It owns the fetch address, decodes all control-flow instructions in the execute phase, and holds the resolved target in a dedicated pending register until the branch delay slot has retired. This means a taken branch is never lost. It also signals halt when control transfers to the configured halt address, and raises an alignment fault on misaligned register jumps.

## Interface
- RESET_VECTOR, default 32'hBFC0_0000: address loaded on reset.
- HALT_ADDR, default 32'h0000_0000: control transfer to this address ends execution.
- DELAY_SLOT, default 1: 1 = MIPS delay-slot semantics; 0 = redirect takes effect immediately.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- state  in  1  core phase: 0 = fetch, 1 = execute.
- stall  in  1  freezes all PC and FSM updates when high.
- N  in  1  ALU negative flag for the instruction in execute.
- Z  in  1  ALU zero flag for the instruction in execute.
- instruction_word  in  32  instruction currently in execute.
- read_data_0  in  32  rs register value (JR/JALR target).
- addr  out  32  registered instruction fetch address.
- B_link  out  1  combinational; high while a linking instruction is executing.
- link_addr  out  32  return address to write to the link register.
- finish  out  1  registered; high once halted.
- addr_err  out  1  registered; sticky misaligned-target fault.

## Operation
- Update condition: the unit advances only on a posedge with state=1, stall=0, and FSM not HALTED.
- Decode uses opcode [31:26], regimm rt [20:16], and funct [5:0].
- Branch conditions:
  - BEQ: Z. BNE: !Z.
  - BLEZ: N|Z. BGTZ: !N&!Z.
  - BLTZ/BLTZAL: N. BGEZ/BGEZAL: !N.
- Targets (32-bit modular arithmetic, wrap ignored):
  - Branch: addr+4+(sext(imm16)<<2).
  - J/JAL: {addr+4 [31:28], idx26, 2'b00}.
  - JR/JALR: read_data_0.
- Link:
  - B_link=1 for JAL, JALR, BLTZAL, BGEZAL, regardless of whether the branch is taken.
  - link_addr = addr+8 when DELAY_SLOT=1, addr+4 when DELAY_SLOT=0.
- FSM states: RUN, DELAY, HALTED.
  - RUN, no taken transfer: addr <= addr+4.
  - RUN, taken transfer, DELAY_SLOT=1: addr <= addr+4, pending <= target, go to DELAY.
  - RUN, taken transfer, DELAY_SLOT=0: addr <= target.
  - DELAY: addr <= pending, go to RUN. A control-flow instruction in the delay slot is ignored, including its B_link.
  - Entering the target: if target == HALT_ADDR, go to HALTED, finish <= 1, addr held at its current value.
  - JR/JALR with read_data_0[1:0] != 0: addr_err <= 1 and go to HALTED (finish <= 1). No delay slot is executed.
  - HALTED is left only by reset.
- Reset values: addr=RESET_VECTOR, FSM=RUN, pending=0, finish=0, addr_err=0. Reset overrides stall and state, and clears any in-flight DELAY.

## Timing
- addr changes exactly one posedge after an execute-phase edge; no change on fetch-phase edges.
- Taken-branch latency with DELAY_SLOT=1: branch at A executes, then A+4 executes, then the target is fetched.
- The pending target persists across any number of stalled cycles and fetch phases.
- finish and addr_err rise on the same edge that would have loaded HALT_ADDR or the bad target.
- B_link and link_addr are valid only while state=1; they are don't-care otherwise.

## Structure
- Package pc_pkg holds:
  - opcode, regimm and funct localparams;
  - typedef enum pc_state_t {RUN, DELAY, HALTED}.
- Sub-module pc_branch_decode is purely combinational. It takes instruction_word, N, Z, addr and read_data_0, and produces taken, target, is_link and is_reg_jump.
- pc_unit holds the FSM, the addr and pending registers, and the flags.

## Test plan
- Reset, then execute non-branch 32'h0060_000B three times -> addr BFC00000, BFC00004, BFC00008, BFC0000C.
- Clear at RESET_VECTOR=0, HALT_ADDR=32'hFFFF_FFFC (DELAY_SLOT=1) so it does not halt immediately. Execute BLTZ 32'h0400_0002 at addr 8 with N=1, then a NOP -> addr 12, then 20. Same instruction with N=0 -> addr 12, 16.
- JAL idx=4 at 0x100 -> B_link=1, link_addr=0x108. Next addr 0x104, then 0x010.
- With HALT_ADDR=0, JR executed with read_data_0=0, then the delay slot -> finish=1 after the delay slot, addr frozen for 10 further cycles, no further updates.
- JR with read_data_0=0x1002 -> addr_err=1 and finish=1 on the next execute edge.
- Stall high for 5 cycles while in DELAY -> addr unchanged. On release, addr=pending target. Reset asserted in DELAY -> addr=RESET_VECTOR, FSM=RUN.
- DELAY_SLOT=0 build: BEQ with Z=1, imm=3 at 0x20 -> next addr 0x30.
